spi_master_ctrl: RTL



---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_master_ctrl_if.sv | 20 ++
 rtl/spi_sck_tick.sv | 28 ++
 rtl/spi_master_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI master transaction controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        XFER     = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4
    } spi_state_e;

    localparam int SPI_DATA_W_DEF   = 8;
    localparam int SPI_HALF_DIV_DEF = 10;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Request/response handshake and SPI pin bundle between command logic and the SPI controller.
interface spi_master_ctrl_if #(
    parameter int DATA_W = spi_pkg::SPI_DATA_W_DEF
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sck;
    logic              cs_n;
    logic              mosi;
    logic              miso;

    // master: the requesting side (and pin-level environment); slave: the controller itself
    modport master (output start, tx_data, miso,
                    input  busy, done, rx_data, sck, cs_n, mosi);
    modport slave  (input  start, tx_data, miso,
                    output busy, done, rx_data, sck, cs_n, mosi);
endinterface

// File: rtl/spi_sck_tick.sv
// Half-period timer: counts 0..HALF_DIV-1 and flags the terminal count for one cycle.
module spi_sck_tick #(
    parameter int HALF_DIV = spi_pkg::SPI_HALF_DIV_DEF
) (
    input  logic clk_100mhz,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int              CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Free-running half-period count, held at zero while cleared
    always_ff @(posedge clk_100mhz) begin
        if (reset || clr) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 MSB-first single-word transaction controller with SCK sequenced from clk_100mhz.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W_DEF,
    parameter int HALF_DIV = SPI_HALF_DIV_DEF
) (
    input logic             clk_100mhz,
    input logic             reset,
    spi_master_ctrl_if.slave bus
);
    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("spi_master_ctrl: DATA_W must be >= 1");
    end
    if (HALF_DIV < 2) begin : g_bad_half_div
        $error("spi_master_ctrl: HALF_DIV must be >= 2");
    end

    spi_state_e        state_r;
    logic [DATA_W-1:0] tx_sh_r;
    logic [DATA_W-1:0] rx_sh_r;
    logic [DATA_W-1:0] rx_data_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              sck_r;
    logic              cs_n_r;
    logic              mosi_r;
    logic              tick_s;
    logic              clr_s;
    logic              accept_s;
    logic [DATA_W-1:0] tx_next_s;
    logic [DATA_W-1:0] rx_next_s;

    // Timer sits at zero in IDLE; every other state entry lands on a tick, where it wraps to zero.
    assign clr_s     = (state_r == IDLE);
    // A held start restarts straight out of GAP so cs_n stays high for exactly one half-period.
    assign accept_s  = bus.start && ((state_r == IDLE) || ((state_r == GAP) && tick_s));
    assign tx_next_s = tx_sh_r << 1;
    assign rx_next_s = (rx_sh_r << 1) | DATA_W'(bus.miso);

    spi_sck_tick #(.HALF_DIV(HALF_DIV)) u_tick (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .clr        (clr_s),
        .tick       (tick_s)
    );

    // Transaction FSM with shift registers and registered pin outputs
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_r   <= IDLE;
            tx_sh_r   <= '0;
            rx_sh_r   <= '0;
            rx_data_r <= '0;
            bit_cnt_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sck_r     <= 1'b0;
            cs_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                state_r   <= CS_SETUP;
                tx_sh_r   <= bus.tx_data;
                mosi_r    <= bus.tx_data[DATA_W-1];
                bit_cnt_r <= '0;
                busy_r    <= 1'b1;
                cs_n_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        busy_r <= 1'b0;
                    end
                    CS_SETUP: begin
                        if (tick_s) begin
                            sck_r   <= 1'b1;
                            rx_sh_r <= rx_next_s;
                            state_r <= XFER;
                        end
                    end
                    XFER: begin
                        if (tick_s && !sck_r) begin
                            sck_r   <= 1'b1;
                            rx_sh_r <= rx_next_s;
                        end else if (tick_s) begin
                            sck_r <= 1'b0;
                            if (bit_cnt_r == LAST_BIT) begin
                                mosi_r  <= 1'b0;
                                state_r <= CS_HOLD;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                                tx_sh_r   <= tx_next_s;
                                mosi_r    <= tx_next_s[DATA_W-1];
                            end
                        end
                    end
                    CS_HOLD: begin
                        if (tick_s) begin
                            cs_n_r    <= 1'b1;
                            done_r    <= 1'b1;
                            rx_data_r <= rx_sh_r;
                            state_r   <= GAP;
                        end
                    end
                    GAP: begin
                        if (tick_s) begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        sck_r   <= 1'b0;
                        cs_n_r  <= 1'b1;
                        mosi_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.rx_data = rx_data_r;
    assign bus.sck     = sck_r;
    assign bus.cs_n    = cs_n_r;
    assign bus.mosi    = mosi_r;

endmodule
